// File: rtl/axi_mem_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_mem_slave_if : AXI4 bus bundle (no IDs) with master/slave views  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface axi_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic                    WVALID;
  logic                    WLAST;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WREADY;
  logic                    BVALID;
  logic [1:0]              BRESP;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic                    RVALID;
  logic                    RLAST;
  logic [1:0]              RRESP;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST, output AWREADY,
    input  WDATA, WVALID, WLAST, WSTRB,             output WREADY,
    output BVALID, BRESP,                            input  BREADY,
    input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, output ARREADY,
    output RDATA, RVALID, RLAST, RRESP,              input  RREADY
  );

  modport master (
    output AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST, input  AWREADY,
    output WDATA, WVALID, WLAST, WSTRB,             input  WREADY,
    input  BVALID, BRESP,                            output BREADY,
    output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, input  ARREADY,
    input  RDATA, RVALID, RLAST, RRESP,              output RREADY
  );
endinterface
`default_nettype wire

// File: rtl/axi_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_mem_slave : AXI4 INCR-burst slave over a word-addressed RAM      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axi_mem_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 128,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0
) (
  input  logic            clk,
  input  logic            rst,
  axi_mem_slave_if.slave  axi
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int SHIFT  = $clog2(BYTES);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WORD_W = ADDR_WIDTH - SHIFT;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rd_q;

  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_cnt_q, w_cnt_d, w_len_q, w_len_d;
  logic                  w_legal_q, w_legal_d, w_err_q, w_err_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_cnt_q, r_cnt_d, r_len_q, r_len_d;
  logic                  r_legal_q, r_legal_d, rok_q, rok_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;

  // Extra top bit of the difference is the borrow: set when the address lies below MEM_BASE.
  logic [ADDR_WIDTH:0] w_diff, r_diff;
  logic                w_in_range, r_in_range, w_last, r_last, w_we, unused_low;
  logic [IDX_W-1:0]    w_idx, r_idx;

  assign w_diff     = {1'b0, w_addr_q} - {1'b0, MEM_BASE};
  assign r_diff     = {1'b0, r_addr_q} - {1'b0, MEM_BASE};
  assign w_in_range = !w_diff[ADDR_WIDTH] && (w_diff[ADDR_WIDTH-1:SHIFT] < WORD_W'(DEPTH));
  assign r_in_range = !r_diff[ADDR_WIDTH] && (r_diff[ADDR_WIDTH-1:SHIFT] < WORD_W'(DEPTH));
  assign w_idx      = w_diff[SHIFT +: IDX_W];
  assign r_idx      = r_diff[SHIFT +: IDX_W];
  assign w_last     = (w_cnt_q == w_len_q);
  assign r_last     = (r_cnt_q == r_len_q);
  assign unused_low = ^{w_diff[SHIFT-1:0], r_diff[SHIFT-1:0]};

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_cnt_d   = w_cnt_q;
    w_len_d   = w_len_q;
    w_legal_d = w_legal_q;
    w_err_d   = w_err_q;
    bresp_d   = bresp_q;
    w_we      = 1'b0;
    unique case (w_state_q)
      W_IDLE: if (awready_q && axi.AWVALID) begin
        w_addr_d  = axi.AWADDR;
        w_len_d   = axi.AWLEN;
        w_cnt_d   = 8'd0;
        w_legal_d = (axi.AWSIZE == 3'(SHIFT)) && (axi.AWBURST == 2'b01);
        w_err_d   = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (axi.WVALID) begin
        w_we     = w_legal_q && w_in_range;
        w_err_d  = w_err_q | (axi.WLAST != w_last) | !w_in_range;
        w_addr_d = w_addr_q + ADDR_WIDTH'(BYTES);
        w_cnt_d  = w_cnt_q + 8'd1;
        if (w_last) begin
          w_state_d = W_RESP;
          bresp_d   = (w_err_d || !w_legal_q) ? 2'b10 : 2'b00;
        end
      end
      W_RESP: if (axi.BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_cnt_d   = r_cnt_q;
    r_len_d   = r_len_q;
    r_legal_d = r_legal_q;
    rok_d     = rok_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    unique case (r_state_q)
      R_IDLE: if (arready_q && axi.ARVALID) begin
        r_addr_d  = axi.ARADDR;
        r_len_d   = axi.ARLEN;
        r_cnt_d   = 8'd0;
        r_legal_d = (axi.ARSIZE == 3'(SHIFT)) && (axi.ARBURST == 2'b01);
        r_state_d = R_FETCH;
      end
      R_FETCH: begin
        rok_d     = r_legal_q && r_in_range;
        rresp_d   = rok_d ? 2'b00 : 2'b10;
        rlast_d   = r_last;
        r_state_d = R_DATA;
      end
      R_DATA: if (axi.RREADY) begin
        rlast_d = 1'b0;
        if (rlast_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_addr_d  = r_addr_q + ADDR_WIDTH'(BYTES);
          r_cnt_d   = r_cnt_q + 8'd1;
          r_state_d = R_FETCH;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_cnt_q   <= '0;
      w_len_q   <= '0;
      w_legal_q <= 1'b0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_cnt_q   <= '0;
      r_len_q   <= '0;
      r_legal_q <= 1'b0;
      rok_q     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_cnt_q   <= w_cnt_d;
      w_len_q   <= w_len_d;
      w_legal_q <= w_legal_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_cnt_q   <= r_cnt_d;
      r_len_q   <= r_len_d;
      r_legal_q <= r_legal_d;
      rok_q     <= rok_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
    end
  end

  // Unreset RAM port: a read and a write to one word in the same cycle return the old data.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (axi.WSTRB[b]) mem[w_idx][8*b +: 8] <= axi.WDATA[8*b +: 8];
      end
    end
    if (r_state_q == R_FETCH) mem_rd_q <= mem[r_idx];
  end

  assign axi.AWREADY = awready_q;
  assign axi.WREADY  = wready_q;
  assign axi.BVALID  = bvalid_q;
  assign axi.BRESP   = bresp_q;
  assign axi.ARREADY = arready_q;
  assign axi.RVALID  = rvalid_q;
  assign axi.RLAST   = rlast_q;
  assign axi.RRESP   = rresp_q;
  assign axi.RDATA   = (rvalid_q && rok_q) ? mem_rd_q : '0;
endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_mem_slave : directed self-checking bench for axi_mem_slave    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_axi_mem_slave;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) bus ();
  axi_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(128), .DEPTH(1024), .MEM_BASE(32'h0))
    dut (.clk(clk), .rst(rst), .axi(bus));

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] wd [16];
  logic [15:0]  ws [16];
  logic [127:0] rd_data [16];
  logic [1:0]   rd_resp [16];
  logic         rd_last [16];
  logic [1:0]   resp;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int early, output logic [1:0] bresp);
    int t;
    @(negedge clk);
    bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst; bus.AWVALID = 1'b1;
    t = 0; while (!bus.AWREADY && t < 50) begin @(negedge clk); t++; end
    check("awready", bus.AWREADY, 1);
    @(negedge clk);
    bus.AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.WDATA = wd[i]; bus.WSTRB = ws[i];
      bus.WLAST = (i == early) || (i == int'(len));
      bus.WVALID = 1'b1;
      t = 0; while (!bus.WREADY && t < 50) begin @(negedge clk); t++; end
      check("wready", bus.WREADY, 1);
      @(negedge clk);
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    check("bvalid_latency", bus.BVALID, 1);
    bus.BREADY = 1'b1;
    t = 0; while (!bus.BVALID && t < 50) begin @(negedge clk); t++; end
    bresp = bus.BRESP;
    @(negedge clk);
    bus.BREADY = 1'b0;
    check("bvalid_drop", bus.BVALID, 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input bit stall);
    int t;
    logic [127:0] d;
    @(negedge clk);
    bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = 3'd4; bus.ARBURST = 2'b01; bus.ARVALID = 1'b1;
    bus.RREADY = !stall;
    t = 0; while (!bus.ARREADY && t < 50) begin @(negedge clk); t++; end
    check("arready", bus.ARREADY, 1);
    @(negedge clk);
    bus.ARVALID = 1'b0;
    check("r_fetch_gap", bus.RVALID, 0);
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      t = 0; while (!bus.RVALID && t < 50) begin @(negedge clk); t++; end
      check("r_latency", 128'(t), 0);
      if (stall) begin
        d = bus.RDATA;
        repeat (2) begin
          @(negedge clk);
          check("r_hold_data", bus.RDATA, d);
          check("r_hold_valid", bus.RVALID, 1);
        end
        bus.RREADY = 1'b1;
      end
      rd_data[i] = bus.RDATA; rd_resp[i] = bus.RRESP; rd_last[i] = bus.RLAST;
      @(negedge clk);
      if (stall) bus.RREADY = 1'b0;
      check("r_beat_gap", bus.RVALID, 0);
    end
    check("arready_after_last", bus.ARREADY, 1);
    bus.RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.AWADDR = '0; bus.AWVALID = 0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.WDATA = '0; bus.WVALID = 0; bus.WLAST = 0; bus.WSTRB = '0; bus.BREADY = 0;
    bus.ARADDR = '0; bus.ARVALID = 0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
    bus.RREADY = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctl", {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID,
                        bus.RLAST, bus.BRESP, bus.RRESP}, 0);
    check("reset_rdata", bus.RDATA, 0);
    rst = 1'b1;
    @(negedge clk);
    check("awready_after_reset", bus.AWREADY, 1);
    check("arready_after_reset", bus.ARREADY, 1);

    // Single-beat write then read
    wd[0] = 128'h0123456789ABCDEF0123456789ABCDEF; ws[0] = 16'hFFFF;
    axi_write(32'h40, 8'd0, 3'd4, 2'b01, -1, resp);
    check("single_bresp", resp, 2'b00);
    axi_read(32'h40, 8'd0, 0);
    check("single_rdata", rd_data[0], 128'h0123456789ABCDEF0123456789ABCDEF);
    check("single_rresp", rd_resp[0], 2'b00);
    check("single_rlast", rd_last[0], 1);

    // Strobed 4-beat burst over a prefilled region
    for (int i = 0; i < 4; i++) begin wd[i] = pat(8'hA0 + 8'(i)); ws[i] = 16'hFFFF; end
    axi_write(32'h100, 8'd3, 3'd4, 2'b01, -1, resp);
    check("prefill_bresp", resp, 2'b00);
    for (int i = 0; i < 4; i++) begin
      wd[i] = pat(8'hB0 + 8'(i)); ws[i] = (i == 2) ? 16'h000F : 16'hFFFF;
    end
    axi_write(32'h100, 8'd3, 3'd4, 2'b01, -1, resp);
    check("strobe_bresp", resp, 2'b00);
    axi_read(32'h100, 8'd3, 0);
    check("strobe_b0", rd_data[0], 128'hB0B0B0B0_B0B0B0B0_B0B0B0B0_B0B0B0B0);
    check("strobe_b1", rd_data[1], 128'hB1B1B1B1_B1B1B1B1_B1B1B1B1_B1B1B1B1);
    check("strobe_b2", rd_data[2], 128'hA2A2A2A2_A2A2A2A2_A2A2A2A2_B2B2B2B2);
    check("strobe_b3", rd_data[3], 128'hB3B3B3B3_B3B3B3B3_B3B3B3B3_B3B3B3B3);
    for (int i = 0; i < 4; i++) check("strobe_rlast", rd_last[i], (i == 3));

    // 8-beat read under backpressure
    for (int i = 0; i < 8; i++) begin wd[i] = pat(8'hC0 + 8'(i)); ws[i] = 16'hFFFF; end
    axi_write(32'h300, 8'd7, 3'd4, 2'b01, -1, resp);
    check("bp_bresp", resp, 2'b00);
    axi_read(32'h300, 8'd7, 1);
    for (int i = 0; i < 8; i++) begin
      check("bp_rdata", rd_data[i], pat(8'hC0 + 8'(i)));
      check("bp_rlast", rd_last[i], (i == 7));
    end

    // Read running off the end of memory (index 1022, four beats)
    axi_read(32'h3FE0, 8'd3, 0);
    check("oor_resp0", rd_resp[0], 2'b00);
    check("oor_resp1", rd_resp[1], 2'b00);
    check("oor_resp2", rd_resp[2], 2'b10);
    check("oor_resp3", rd_resp[3], 2'b10);
    check("oor_data2", rd_data[2], 0);
    check("oor_data3", rd_data[3], 0);
    check("oor_last3", rd_last[3], 1);

    // Illegal size / burst type leave memory untouched
    wd[0] = pat(8'hEE); wd[1] = pat(8'hEF); ws[0] = 16'hFFFF; ws[1] = 16'hFFFF;
    axi_write(32'h40, 8'd0, 3'd2, 2'b01, -1, resp);
    check("bad_size_bresp", resp, 2'b10);
    axi_write(32'h40, 8'd1, 3'd4, 2'b00, -1, resp);
    check("fixed_burst_bresp", resp, 2'b10);
    axi_read(32'h40, 8'd0, 0);
    check("illegal_no_write", rd_data[0], 128'h0123456789ABCDEF0123456789ABCDEF);

    // Early WLAST
    for (int i = 0; i < 4; i++) begin wd[i] = pat(8'h50 + 8'(i)); ws[i] = 16'hFFFF; end
    axi_write(32'h500, 8'd3, 3'd4, 2'b01, 1, resp);
    check("early_wlast_bresp", resp, 2'b10);

    // Same-cycle write and read of one word
    wd[0] = pat(8'hD0); ws[0] = 16'hFFFF;
    axi_write(32'h200, 8'd0, 3'd4, 2'b01, -1, resp);
    check("conc_prefill_bresp", resp, 2'b00);
    wd[0] = pat(8'hE0);
    fork
      axi_write(32'h200, 8'd0, 3'd4, 2'b01, -1, resp);
      axi_read(32'h200, 8'd0, 0);
    join
    check("conc_bresp", resp, 2'b00);
    check("conc_old_data", rd_data[0], 128'hD0D0D0D0_D0D0D0D0_D0D0D0D0_D0D0D0D0);
    axi_read(32'h200, 8'd0, 0);
    check("conc_new_data", rd_data[0], 128'hE0E0E0E0_E0E0E0E0_E0E0E0E0_E0E0E0E0);

    // Asynchronous reset in the middle of a 4-beat write
    @(negedge clk);
    bus.AWADDR = 32'h600; bus.AWLEN = 8'd3; bus.AWSIZE = 3'd4; bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.WDATA = pat(8'h60 + 8'(i)); bus.WSTRB = 16'hFFFF; bus.WLAST = 1'b0; bus.WVALID = 1'b1;
      @(negedge clk);
    end
    check("mid_wready", bus.WREADY, 1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_ctl", {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID,
                              bus.RLAST, bus.BRESP, bus.RRESP}, 0);
    check("async_reset_rdata", bus.RDATA, 0);
    bus.WVALID = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY}, 4'b1001);
    repeat (3) @(negedge clk);
    check("no_bresp_after_reset", bus.BVALID, 0);
    axi_read(32'h40, 8'd0, 0);
    check("retained_0x40", rd_data[0], 128'h0123456789ABCDEF0123456789ABCDEF);
    axi_read(32'h200, 8'd0, 0);
    check("retained_0x200", rd_data[0], 128'hE0E0E0E0_E0E0E0E0_E0E0E0E0_E0E0E0E0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
